// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the load/store controller (master) and the memory (slave).
interface mem_access_ctrl_if;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_addr, dmem_we, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_addr, dmem_we, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// RV32I load/store unit: accepts one memory op from execute, drives the data bus,
// formats load results and reports misalignment or bus timeout as one-cycle pulses.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              stall,
  mem_access_ctrl_if.master dmem,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              misalign_exc,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  // The counter starts at 0 on entering REQ, so this value marks the last allowed cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic        op_load;
  logic [2:0]  op_funct3;
  logic [1:0]  op_off;
  logic [4:0]  op_rd;
  logic [31:0] req_addr;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;

  logic        legal_load, legal_store, accept, misaligned, timeout;
  logic [3:0]  store_we;
  logic        load_done, abort;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  always_comb begin
    legal_load  = (ex_funct3 != 3'd3) && (ex_funct3[2:1] != 2'b11);
    legal_store = !ex_funct3[2] && (ex_funct3[1:0] != 2'b11);
    accept      = (state == IDLE) && ex_valid &&
                  (ex_load ? legal_load : (ex_store && legal_store));
    misaligned  = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                  ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
    timeout     = (cnt == TIMEOUT_LAST);
    case (ex_funct3[1:0])
      2'b00:   store_we = 4'b0001 << ex_addr[1:0];
      2'b01:   store_we = 4'b0011 << ex_addr[1:0];
      default: store_we = 4'b1111;
    endcase
  end

  always_comb begin
    state_next = state;
    load_done  = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !misaligned) state_next = REQ;
      end
      REQ: begin
        // A store completes on grant; a load granted in its final allowed cycle still aborts.
        if (dmem.dmem_gnt && !op_load) begin
          state_next = IDLE;
        end else if (timeout) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (dmem.dmem_gnt) begin
          state_next = WAIT_R;
        end
      end
      WAIT_R: begin
        if (dmem.dmem_rvalid) begin
          state_next = IDLE;
          load_done  = 1'b1;
        end else if (timeout) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (op_off)
      2'd0:    lane_byte = dmem.dmem_rdata[7:0];
      2'd1:    lane_byte = dmem.dmem_rdata[15:8];
      2'd2:    lane_byte = dmem.dmem_rdata[23:16];
      default: lane_byte = dmem.dmem_rdata[31:24];
    endcase
    lane_half = op_off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (op_funct3)
      3'd0:    load_data = {{24{lane_byte[7]}}, lane_byte};
      3'd1:    load_data = {{16{lane_half[15]}}, lane_half};
      3'd4:    load_data = {24'd0, lane_byte};
      3'd5:    load_data = {16'd0, lane_half};
      default: load_data = dmem.dmem_rdata;
    endcase
  end

  assign stall            = (state != IDLE);
  assign dmem.dmem_req    = (state == REQ);
  assign dmem.dmem_addr   = (state == REQ) ? req_addr  : 32'd0;
  assign dmem.dmem_we     = (state == REQ) ? req_we    : 4'd0;
  assign dmem.dmem_wdata  = (state == REQ) ? req_wdata : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      op_load      <= 1'b0;
      op_funct3    <= 3'd0;
      op_off       <= 2'd0;
      op_rd        <= 5'd0;
      req_addr     <= 32'd0;
      req_we       <= 4'd0;
      req_wdata    <= 32'd0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state        <= state_next;
      wb_valid     <= load_done;
      misalign_exc <= accept && misaligned;
      bus_err      <= abort;
      if (accept && !misaligned) begin
        cnt       <= 8'd0;
        op_load   <= ex_load;
        op_funct3 <= ex_funct3;
        op_off    <= ex_addr[1:0];
        op_rd     <= ex_rd;
        req_addr  <= {ex_addr[31:2], 2'b00};
        req_we    <= ex_load ? 4'd0 : store_we;
        req_wdata <= ex_load ? 32'd0 : (ex_wdata << {ex_addr[1:0], 3'b000});
      end else if (state != IDLE) begin
        cnt <= cnt + 8'd1;
      end
      if (load_done) begin
        wb_rd   <= op_rd;
        wb_data <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the stimulus process predicts bus requests and
// result pulses from the ISA rules; a negedge monitor pops and compares them.
module tb_mem_access_ctrl;

  localparam int N      = 4;
  localparam int K_REQ  = 0;
  localparam int K_WB   = 1;
  localparam int K_MIS  = 2;
  localparam int K_BERR = 3;

  typedef struct {
    int          kind;
    int          lo;
    int          cyc;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_exc, bus_err;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_load      (ex_load),
    .ex_store     (ex_store),
    .ex_funct3    (ex_funct3),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .ex_rd        (ex_rd),
    .stall        (stall),
    .dmem         (bus.master),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .misalign_exc (misalign_exc),
    .bus_err      (bus_err)
  );

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  logic mon_en = 1'b0;
  logic exp_stall = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
  endfunction

  // Reference load formatting straight from the ISA: pick the lane, then extend.
  function automatic logic [31:0] model_load(logic [2:0] f3, int off, logic [31:0] rdata);
    logic [31:0] v;
    if (f3[1:0] == 2'b00) begin
      v = (rdata >> (8 * off)) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else if (f3[1:0] == 2'b01) begin
      v = (rdata >> (8 * off)) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op at the current cycle and play the memory side with grant after g
  // REQ cycles and rvalid r cycles after the grant; returns in the first idle cycle.
  task automatic apply_stimulus(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd, input int g, input int r,
                                input logic [31:0] rdata);
    int   t, bytes, off, need, busy;
    logic legal, mis;
    exp_t e;
    t     = cyc;
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
               : (st && (f3 inside {3'd0, 3'd1, 3'd2}));
    bytes = 1 << f3[1:0];
    off   = int'(addr % 4);
    mis   = (addr % bytes) != 0;
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'($urandom_range(0, 1)); bus.dmem_rdata = $urandom;
    exp_stall = 1'b0;
    busy = 0;
    e.addr = 0; e.we = 0; e.wdata = 0; e.chk_wdata = 0; e.rd = 0; e.data = 0; e.lo = 0;
    if (legal && mis) begin
      e.kind = K_MIS; e.cyc = t + 1;
      sb.push_back(e);
    end else if (legal) begin
      need = ld ? g + r + 2 : g + 1;
      busy = (need <= N) ? need : N;
      e.kind = K_REQ; e.lo = t + 1; e.cyc = t + 1 + ((g < N) ? g : N - 1);
      e.addr = addr & ~32'h3;
      e.we = ld ? 4'd0 : 4'(((1 << bytes) - 1) << off);
      e.wdata = wdata << (8 * off);
      e.chk_wdata = !ld;
      sb.push_back(e);
      if (need > N) begin
        e.kind = K_BERR; e.cyc = t + 1 + N;
        sb.push_back(e);
      end else if (ld) begin
        e.kind = K_WB; e.cyc = t + g + r + 3; e.rd = rd;
        e.data = model_load(f3, off, rdata);
        sb.push_back(e);
      end
    end
    for (int c = 0; c < busy; c++) begin
      next_cycle();
      exp_stall = 1'b1;
      ex_valid = 1'($urandom_range(0, 1)); ex_load = 1'($urandom_range(0, 1));
      ex_store = 1'($urandom_range(0, 1)); ex_funct3 = 3'($urandom_range(0, 7));
      ex_addr = $urandom; ex_wdata = $urandom; ex_rd = 5'($urandom_range(0, 31));
      bus.dmem_gnt = (c == g);
      if (ld && c == g + 1 + r) begin
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rdata;
      end else if (ld && c > g) begin
        bus.dmem_rvalid = 1'b0; bus.dmem_rdata = $urandom;
      end else begin
        bus.dmem_rvalid = 1'($urandom_range(0, 1)); bus.dmem_rdata = $urandom;
      end
    end
    next_cycle();
    exp_stall = 1'b0;
    ex_valid = 1'b0; bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check_output({tag, "_stall"}, stall, 0);
    check_output({tag, "_req"}, bus.dmem_req, 0);
    check_output({tag, "_we"}, bus.dmem_we, 0);
    check_output({tag, "_addr"}, bus.dmem_addr, 0);
    check_output({tag, "_wdata"}, bus.dmem_wdata, 0);
    check_output({tag, "_pulses"}, {wb_valid, misalign_exc, bus_err}, 0);
    check_output({tag, "_wb_rd"}, wb_rd, 0);
    check_output({tag, "_wb_data"}, wb_data, 0);
  endtask

  // Load granted at once, reset lands in WAIT_R, rvalid arrives right after: op must vanish.
  task automatic reset_in_wait();
    exp_t e;
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'd2;
    ex_addr = 32'h40; ex_wdata = 0; ex_rd = 5'd9;
    e.kind = K_REQ; e.lo = cyc + 1; e.cyc = cyc + 1; e.addr = 32'h40; e.we = 0;
    e.wdata = 0; e.chk_wdata = 0; e.rd = 0; e.data = 0;
    sb.push_back(e);
    next_cycle();
    ex_valid = 1'b0; exp_stall = 1'b1; bus.dmem_gnt = 1'b1;
    next_cycle();
    bus.dmem_gnt = 1'b0; rst = 1'b1;
    next_cycle();
    rst = 1'b0; exp_stall = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
    check_all_zero("rst_wait");
    next_cycle();
    bus.dmem_rvalid = 1'b0;
    check_all_zero("rst_after_rvalid");
  endtask

  exp_t       m_f;
  logic       m_exp_req, m_popped;
  logic [2:0] m_exp_p;

  always @(negedge clk) begin
    if (mon_en) begin
      check_output("stall", stall, exp_stall);
      m_exp_req = (sb.size() > 0) && (sb[0].kind == K_REQ) && (cyc >= sb[0].lo) && (cyc <= sb[0].cyc);
      check_output("dmem_req", bus.dmem_req, m_exp_req);
      if (m_exp_req) begin
        check_output("dmem_addr", bus.dmem_addr, sb[0].addr);
        check_output("dmem_we", bus.dmem_we, sb[0].we);
        if (sb[0].chk_wdata) check_output("dmem_wdata", bus.dmem_wdata, sb[0].wdata);
        if (cyc == sb[0].cyc) m_f = sb.pop_front();
      end else begin
        check_output("dmem_we_idle", bus.dmem_we, 0);
      end
      m_exp_p = 3'b000;
      m_popped = 1'b0;
      if ((sb.size() > 0) && (sb[0].kind != K_REQ) && (sb[0].cyc == cyc)) begin
        m_f = sb.pop_front();
        m_popped = 1'b1;
        case (m_f.kind)
          K_WB:    m_exp_p = 3'b100;
          K_MIS:   m_exp_p = 3'b010;
          default: m_exp_p = 3'b001;
        endcase
      end
      check_output("pulses{wb,mis,berr}", {wb_valid, misalign_exc, bus_err}, m_exp_p);
      if (m_popped && m_f.kind == K_WB) begin
        check_output("wb_rd", wb_rd, m_f.rd);
        check_output("wb_data", wb_data, m_f.data);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          kind;
    rst = 1'b1;
    ex_valid = 0; ex_load = 0; ex_store = 0; ex_funct3 = 0; ex_addr = 0; ex_wdata = 0; ex_rd = 0;
    bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = 0;
    repeat (3) next_cycle();
    check_all_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    next_cycle();

    $display("[TB] directed cases");
    apply_stimulus(1, 0, 3'd0, 32'h1003, 32'h0, 5'd3, 0, 0, 32'h80FFEE11);
    apply_stimulus(0, 1, 3'd1, 32'h2002, 32'h0000BEEF, 5'd0, 3, 0, 32'h0);
    apply_stimulus(1, 0, 3'd2, 32'h0006, 32'h0, 5'd4, 0, 0, 32'h0);
    apply_stimulus(1, 0, 3'd2, 32'h0100, 32'h0, 5'd5, 0, 20, 32'h0);
    apply_stimulus(1, 1, 3'd5, 32'h0010, 32'h12345678, 5'd6, 0, 0, 32'h1234F00D);
    apply_stimulus(0, 1, 3'd3, 32'h0020, 32'h11111111, 5'd0, 0, 0, 32'h0);
    apply_stimulus(1, 0, 3'd7, 32'h0024, 32'h0, 5'd7, 0, 0, 32'h0);
    reset_in_wait();
    next_cycle();

    $display("[TB] random cases");
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 3);
      ld   = (kind == 1) || (kind == 3);
      st   = (kind >= 2);
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      if ($urandom_range(0, 4) == 0) next_cycle();
      apply_stimulus(ld, st, f3, addr, $urandom, 5'($urandom_range(0, 31)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    repeat (8) next_cycle();
    check_output("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, max cycles spent in REQ plus WAIT_R before abort (range 1..255, 8-bit counter).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- ex_valid  in  1  execute stage presents a memory op.
- ex_load  in  1  op is a load.
- ex_store  in  1  op is a store.
- ex_funct3  in  3  RV32I load/store funct3.
- ex_addr  in  32  effective byte address.
- ex_wdata  in  32  store source register value.
- ex_rd  in  5  load destination register.
- stall  out  1  block busy; upstream holds the next op.
- dmem_req  out  1  memory request valid.
- dmem_addr  out  32  word-aligned address.
- dmem_we  out  4  byte write enables; 0 for loads.
- dmem_wdata  out  32  lane-aligned store data.
- dmem_gnt  in  1  memory accepts the request this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  raw read word.
- wb_valid  out  1  one-cycle load writeback pulse.
- wb_rd  out  5  writeback register.
- wb_data  out  32  formatted load result.
- misalign_exc  out  1  one-cycle misalignment pulse.
- bus_err  out  1  one-cycle timeout pulse.

Function
REQ-003 SHALL implement FSM states IDLE, REQ and WAIT_R. stall SHALL be combinational (state != IDLE).
REQ-004 Accept condition: state IDLE, ex_valid=1, (ex_load|ex_store)=1 and legal funct3. Legal load funct3: 0, 1, 2, 4, 5. Legal store funct3: 0, 1, 2. If ex_load and ex_store are both 1, the op SHALL be treated as a load.
REQ-005 An op with illegal funct3 SHALL be ignored: no request, no exception.
REQ-006 While stall=1, all ex_* inputs SHALL be ignored.
REQ-007 Misaligned op (half with addr[0]=1, word with addr[1:0]!=0) SHALL NOT issue a request. misalign_exc SHALL pulse in the cycle after acceptance, and the FSM SHALL stay in IDLE.
REQ-008 On an aligned accept, the block SHALL latch the op and enter REQ.
REQ-009 In REQ, the block SHALL drive:
- dmem_req=1 and dmem_addr={addr[31:2],2'b00}.
- Store data shifted by 8*addr[1:0]. Store enables: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111.
REQ-010 All dmem_* outputs SHALL be held stable in REQ until dmem_gnt=1. Outside REQ: dmem_req=0, dmem_we=0.
REQ-011 On grant in REQ: a store SHALL go to IDLE with no writeback; a load SHALL go to WAIT_R. dmem_rvalid SHALL be ignored outside WAIT_R.
REQ-012 On dmem_rvalid in WAIT_R, the block SHALL register the formatted result and go to IDLE, with wb_valid=1 for exactly the next cycle. Formatting:
- LB/LBU: byte at addr[1:0], sign- or zero-extended.
- LH/LHU: half at addr[1], sign- or zero-extended.
- LW: word unchanged.
REQ-013 Latency with immediate grant and rvalid one cycle later, accept at cycle T:
- Load: dmem_req at T+1, rvalid at T+2, wb_valid at T+3.
- Store: dmem_req at T+1, IDLE at T+2.
REQ-014 Timeout counter: cleared on entering REQ, incremented each cycle in REQ or WAIT_R. On reaching TIMEOUT_CYCLES, the op SHALL be aborted: bus_err pulses the next cycle, FSM goes to IDLE, no wb_valid is issued.
REQ-015 wb_valid, misalign_exc and bus_err SHALL each be a single-cycle pulse, mutually exclusive.

Reset
REQ-016 When rst=1 at a clock edge:
- FSM SHALL go to IDLE and the counter to 0.
- stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_rd, wb_data, misalign_exc and bus_err SHALL all be 0.
REQ-017 Reset during REQ or WAIT_R SHALL drop the op silently: no writeback, no exception; a later dmem_rvalid SHALL be ignored.

Verification
REQ-018 The bench SHALL cover:
- LB addr 0x1003, rdata 0x80FFEE11, gnt at T+1, rvalid at T+2 -> wb_data 0xFFFFFF80 at T+3, stall high at T+1..T+2.
- SH addr 0x2002, wdata 0x0000BEEF, gnt held low 3 cycles -> dmem_we 1100 and dmem_wdata 0xBEEF0000 stable 4 cycles; no wb_valid.
- LW addr 0x0006 -> misalign_exc pulse at T+1, dmem_req never asserted.
- TIMEOUT_CYCLES=4, load granted but rvalid never arrives -> bus_err pulse, FSM in IDLE, no wb_valid.
- rst asserted in WAIT_R, rvalid the next cycle -> no wb_valid, all outputs 0.
- LHU addr 0x10 (addr[1:0]=00), rdata 0x1234F00D -> wb_data 0x0000F00D; ex_load=ex_store=1 handled as a load.
